// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg: shared PC command encodings and RAS overflow policies. Rev 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_JUMP = 2'b01,
    PC_CALL = 2'b10,
    PC_RET  = 2'b11
  } pc_cmd_e;

  localparam int RAS_OVF_OVERWRITE = 0;
  localparam int RAS_OVF_DISCARD   = 1;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ras_stack: ring-buffer return-address stack with sticky ovf/unf flags. Rev 1.0
// ---------------------------------------------------------------------------
module ras_stack
  import cpu_pkg::*;
#(
  parameter int AW        = 8,
  parameter int RAS_DEPTH = 4,
  parameter int OVF_MODE  = RAS_OVF_OVERWRITE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clear,
  input  logic [AW-1:0]                  push_data,
  output logic [AW-1:0]                  top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic                           empty,
  output logic                           full,
  output logic                           ovf,
  output logic                           unf
);

  localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(RAS_DEPTH);

  logic [AW-1:0] mem [RAS_DEPTH];
  logic [IW-1:0] top_idx;
  logic [IW-1:0] inc_idx;
  logic [IW-1:0] dec_idx;
  logic          do_push;
  logic          do_pop;

  // Explicit wrap so non-power-of-two depths index correctly.
  assign inc_idx = (top_idx == LAST_IDX) ? '0 : top_idx + 1'b1;
  assign dec_idx = (top_idx == '0) ? LAST_IDX : top_idx - 1'b1;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !(full && (OVF_MODE == RAS_OVF_DISCARD));
  assign do_pop  = pop && !empty;
  assign top     = empty ? '0 : mem[top_idx];

  // When full, the slot after the top is the oldest, so a ring push overwrites it.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      top_idx <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else if (clear) begin
      count <= '0;
    end else begin
      if (push && full) ovf <= 1'b1;
      if (pop && empty) unf <= 1'b1;
      if (do_push) begin
        top_idx <= inc_idx;
        if (!full) count <= count + 1'b1;
      end else if (do_pop) begin
        top_idx <= dec_idx;
        count   <= count - 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (!clear && do_push) mem[inc_idx] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/pc_ras_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_ras_unit: fetch-stage PC register, next-PC priority mux and RAS. Rev 1.0
// ---------------------------------------------------------------------------
module pc_ras_unit
  import cpu_pkg::*;
#(
  parameter int            AW        = 8,
  parameter int            RAS_DEPTH = 4,
  parameter int            OVF_MODE  = RAS_OVF_OVERWRITE,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hold,
  input  logic                           flush,
  input  logic [1:0]                     cmd,
  input  logic                           taken,
  input  logic [AW-1:0]                  target,
  output logic [AW-1:0]                  pc,
  output logic [AW-1:0]                  ras_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_next;
  logic          push;
  logic          pop;
  logic          clear;

  assign pc_inc = pc + 1'b1;

  // flush beats hold, hold beats the command.
  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    if (flush) begin
      pc_next = target;
      clear   = 1'b1;
    end else if (!hold) begin
      case (pc_cmd_e'(cmd))
        PC_SEQ:  pc_next = pc_inc;
        PC_JUMP: pc_next = taken ? target : pc_inc;
        PC_CALL: begin
          pc_next = target;
          push    = 1'b1;
        end
        PC_RET: begin
          pop     = 1'b1;
          pc_next = ras_empty ? pc_inc : ras_top;
        end
        default: pc_next = pc_inc;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) pc <= RESET_VEC;
    else     pc <= pc_next;
  end

  ras_stack #(
    .AW       (AW),
    .RAS_DEPTH(RAS_DEPTH),
    .OVF_MODE (OVF_MODE)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .push_data(pc_inc),
    .top      (ras_top),
    .count    (ras_count),
    .empty    (ras_empty),
    .full     (ras_full),
    .ovf      (ras_ovf),
    .unf      (ras_unf)
  );

endmodule
`default_nettype wire

// File: tb/tb_pc_ras_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_ras_unit: directed vector bench for pc_ras_unit (ring and discard). Rev 1.0
// ---------------------------------------------------------------------------
module tb_pc_ras_unit;
  import cpu_pkg::*;

  logic       clk;
  logic       rst;
  logic       hold;
  logic       flush;
  logic [1:0] cmd;
  logic       taken;
  logic [7:0] target;

  logic [7:0] pc_a, top_a, pc_b, top_b;
  logic [2:0] cnt_a, cnt_b;
  logic       empty_a, full_a, ovf_a, unf_a;
  logic       empty_b, full_b, ovf_b, unf_b;

  int n_vec = 0;
  int n_err = 0;

  pc_ras_unit #(.AW(8), .RAS_DEPTH(4), .OVF_MODE(RAS_OVF_OVERWRITE), .RESET_VEC(8'h00)) dut_a (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .cmd(cmd), .taken(taken), .target(target),
    .pc(pc_a), .ras_top(top_a), .ras_count(cnt_a), .ras_empty(empty_a), .ras_full(full_a),
    .ras_ovf(ovf_a), .ras_unf(unf_a)
  );

  pc_ras_unit #(.AW(8), .RAS_DEPTH(4), .OVF_MODE(RAS_OVF_DISCARD), .RESET_VEC(8'h00)) dut_b (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .cmd(cmd), .taken(taken), .target(target),
    .pc(pc_b), .ras_top(top_b), .ras_count(cnt_b), .ras_empty(empty_b), .ras_full(full_b),
    .ras_ovf(ovf_b), .ras_unf(unf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, f, h;
    logic [1:0] c;
    logic       tk;
    logic [7:0] tg;
    logic [7:0] e_pc, e_top;
    logic [2:0] e_cnt;
    logic       e_ovf, e_unf;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic r, f, h, input logic [1:0] c, input logic tk,
                              input logic [7:0] tg, ep, et, input logic [2:0] ec,
                              input logic eo, eu);
    vec_t v;
    v.r = r; v.f = f; v.h = h; v.c = c; v.tk = tk; v.tg = tg;
    v.e_pc = ep; v.e_top = et; v.e_cnt = ec; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change one unit after the rising edge; outputs are sampled there too,
  // half a period away from the falling update edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, f, h, input logic [1:0] c, input logic tk, input logic [7:0] tg);
    rst = r; flush = f; hold = h; cmd = c; taken = tk; target = tg;
    tick();
  endtask

  logic [7:0] ret_a [4];
  logic [7:0] ret_b [4];

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0; cmd = PC_SEQ; taken = 1'b0; target = 8'h00;

    tbl[0]  = mk(1, 0, 0, PC_SEQ,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, PC_SEQ,  0, 8'h00, 8'h01, 8'h00, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, PC_SEQ,  0, 8'h00, 8'h02, 8'h00, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, PC_SEQ,  0, 8'h00, 8'h03, 8'h00, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, PC_JUMP, 1, 8'h10, 8'h10, 8'h00, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, PC_JUMP, 0, 8'h77, 8'h11, 8'h00, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, PC_JUMP, 1, 8'h40, 8'h40, 8'h00, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, PC_JUMP, 1, 8'h77, 8'h40, 8'h00, 0, 0, 0);
    tbl[8]  = mk(0, 0, 1, PC_JUMP, 1, 8'h77, 8'h40, 8'h00, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, PC_JUMP, 1, 8'h20, 8'h20, 8'h00, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, PC_CALL, 0, 8'h30, 8'h30, 8'h21, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, PC_CALL, 0, 8'h50, 8'h50, 8'h31, 2, 0, 0);
    tbl[12] = mk(0, 0, 0, PC_RET,  0, 8'h99, 8'h31, 8'h21, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, PC_RET,  0, 8'h99, 8'h21, 8'h00, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, PC_CALL, 0, 8'hFF, 8'hFF, 8'h22, 1, 0, 0);
    tbl[15] = mk(0, 0, 0, PC_CALL, 0, 8'h10, 8'h10, 8'h00, 2, 0, 0);
    tbl[16] = mk(0, 1, 1, PC_RET,  0, 8'h80, 8'h80, 8'h00, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, PC_RET,  0, 8'h55, 8'h81, 8'h00, 0, 0, 1);
    tbl[18] = mk(0, 0, 0, PC_SEQ,  0, 8'h55, 8'h82, 8'h00, 0, 0, 1);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].h, tbl[i].c, tbl[i].tk, tbl[i].tg);
      chk($sformatf("v%0d pc", i),    pc_a,    tbl[i].e_pc);
      chk($sformatf("v%0d top", i),   top_a,   tbl[i].e_top);
      chk($sformatf("v%0d count", i), cnt_a,   tbl[i].e_cnt);
      chk($sformatf("v%0d empty", i), empty_a, tbl[i].e_cnt == 3'd0);
      chk($sformatf("v%0d full", i),  full_a,  tbl[i].e_cnt == 3'd4);
      chk($sformatf("v%0d ovf", i),   ovf_a,   tbl[i].e_ovf);
      chk($sformatf("v%0d unf", i),   unf_a,   tbl[i].e_unf);
      chk($sformatf("v%0d pc_b", i),  pc_b,    tbl[i].e_pc);
    end

    // Asynchronous reset mid-run: state clears with no clock edge in between.
    rst = 1'b1;
    #1;
    chk("async pc",    pc_a,  8'h00);
    chk("async count", cnt_a, 3'd0);
    chk("async unf",   unf_a, 1'b0);
    tick();
    drive(0, 0, 0, PC_JUMP, 1, 8'hA0);
    chk("ovf start pc", pc_a, 8'hA0);

    // Five nested calls into a depth-4 stack: returns A1, B1, C1, D1, E1.
    drive(0, 0, 0, PC_CALL, 0, 8'hB0);
    drive(0, 0, 0, PC_CALL, 0, 8'hC0);
    drive(0, 0, 0, PC_CALL, 0, 8'hD0);
    drive(0, 0, 0, PC_CALL, 0, 8'hE0);
    chk("fill4 count_a", cnt_a,  3'd4);
    chk("fill4 full_a",  full_a, 1'b1);
    chk("fill4 ovf_a",   ovf_a,  1'b0);
    chk("fill4 ovf_b",   ovf_b,  1'b0);
    drive(0, 0, 0, PC_CALL, 0, 8'hF0);
    chk("call5 pc_a",    pc_a,  8'hF0);
    chk("call5 pc_b",    pc_b,  8'hF0);
    chk("call5 count_a", cnt_a, 3'd4);
    chk("call5 count_b", cnt_b, 3'd4);
    chk("call5 ovf_a",   ovf_a, 1'b1);
    chk("call5 ovf_b",   ovf_b, 1'b1);
    chk("call5 top_a",   top_a, 8'hE1);
    chk("call5 top_b",   top_b, 8'hD1);

    ret_a[0] = 8'hE1; ret_a[1] = 8'hD1; ret_a[2] = 8'hC1; ret_a[3] = 8'hB1;
    ret_b[0] = 8'hD1; ret_b[1] = 8'hC1; ret_b[2] = 8'hB1; ret_b[3] = 8'hA1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, PC_RET, 0, 8'h00);
      chk($sformatf("ret%0d pc_a", k), pc_a, ret_a[k]);
      chk($sformatf("ret%0d pc_b", k), pc_b, ret_b[k]);
      chk($sformatf("ret%0d unf_a", k), unf_a, 1'b0);
    end
    drive(0, 0, 0, PC_RET, 0, 8'h00);
    chk("underflow pc_a",    pc_a,    8'hB2);
    chk("underflow pc_b",    pc_b,    8'hA2);
    chk("underflow unf_a",   unf_a,   1'b1);
    chk("underflow unf_b",   unf_b,   1'b1);
    chk("underflow empty_a", empty_a, 1'b1);
    chk("underflow count_b", cnt_b,   3'd0);

    // Flush redirects but leaves the sticky flags alone.
    drive(0, 1, 0, PC_CALL, 0, 8'h33);
    chk("flush pc_a",    pc_a,  8'h33);
    chk("flush count_a", cnt_a, 3'd0);
    chk("flush ovf_a",   ovf_a, 1'b1);
    chk("flush unf_a",   unf_a, 1'b1);
    chk("flush ovf_b",   ovf_b, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
